decode_ctrl_stage: RTL
======================

DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width (32 or 64); sizes in_pc, out_pc and out_imm.
REQ-002 Parameter: LOAD_USE_LAT, 1, bubble cycles (1..3) required at consumer input between a load and a dependent instruction.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid / in_ready  in / out  1 / 1  upstream handshake.
- in_instr / in_pc  in / in  32 / XLEN  instruction and its PC.
- flush  in  1  synchronous pipeline kill.
- out_valid / out_ready  out / in  1 / 1  downstream handshake.
- out_pc, out_imm  out  XLEN  registered PC; sign-extended immediate.
- out_rs1, out_rs2, out_rd  out  5  register indices.
- alu_op  out  4  ALU operation.
- alu_src, alu_pc_src  out  1  operand B from immediate; operand A from PC.
- branch  out  3  branch condition; 3'b011 = none.
- jump, mem_read, mem_write, reg_write, mem_to_reg, mem_unsigned, illegal  out  1  control flags.
- mem_size  out  2  00 byte, 01 half, 10 word.
- md_en, md_op  out  1 / 3  multiply/divide request and operation.

Function
REQ-004 Single registered stage: all out_* and control outputs come from flops loaded on input accept (in_valid && in_ready), 1-cycle latency.
REQ-005 Control decode per opcode:
- R-type: reg_write, alu_op = {funct7[5], funct3}.
- I-ALU: reg_write, alu_src; alu_op = {funct7[5], funct3} for funct3 001/101, else {0, funct3}.
- Load: reg_write, alu_src, mem_read, mem_to_reg, {mem_unsigned, mem_size} = funct3.
- Store: alu_src, mem_write, mem_size = funct3[1:0].
- Branch: branch = funct3, alu_op = 1000.
- JAL: reg_write, jump.
- JALR: reg_write, alu_src, jump.
- LUI/AUIPC: reg_write, alu_src; AUIPC also alu_pc_src.
REQ-006 Unknown opcode: illegal=1; reg_write, mem_read, mem_write, jump, md_en = 0; branch = 011.
REQ-007 Immediate: I, S, B, U or J format by opcode, sign-extended from bit 31 to XLEN; R-type 0.
REQ-008 rs1 used by R, I-ALU, Load, Store, Branch, JALR; rs2 used by R, Store, Branch; unused indices output as 0.
REQ-009 in_ready = (!out_valid || out_ready) && !stall && !flush-capture; out_valid falls after fire when nothing is accepted.
REQ-010 Load-use stall: stall=1 when in_valid and a used non-zero rs equals hz_rd, and either out_valid holds a load or hz_cnt > 0.
REQ-011 hz_rd and hz_cnt:
- On a load firing out, hz_rd <= its rd and hz_cnt <= LOAD_USE_LAT-1.
- Otherwise hz_cnt decrements, saturating at 0.
REQ-012 While out_valid && !out_ready, every output holds stable.
REQ-013 flush (priority over all):
- Next cycle out_valid=0 and hz_cnt=0.
- in_ready=1 and the input is discarded.
- Concurrent out_ready handshake still completes.

Reset
REQ-014 On rst assertion, immediately: out_valid=0, hz_cnt=0, hz_rd=0, all data and control outputs 0 except branch=011 and mem_size=10; in_ready=1 after release.
REQ-015 Reset mid-stall drops any held instruction; no output pulse on release.

Configuration
REQ-016 Macro RV32M_EN defined: opcode 0110011 with funct7=0000001 gives md_en=1, md_op=funct3, reg_write=1, illegal=0.
REQ-017 RV32M_EN undefined: that encoding gives illegal=1 per REQ-006; md_en and md_op are tied to 0.

Verification
REQ-018 0x00500093 accepted -> next cycle out_valid=1, rd=1, imm=5, alu_src=1, reg_write=1, alu_op=0000.
REQ-019 LOAD_USE_LAT=1, out_ready=1, 0x0000A103 then 0x002101B3 -> out_valid trace lw, 0, add.
REQ-020 LOAD_USE_LAT=2, same pair -> lw, 0, 0, add.
REQ-021 out_ready=0 for 3 cycles with a valid output -> outputs stable, in_ready=0; release -> single fire.
REQ-022 flush while a load is held and hz_cnt=1 -> next cycle out_valid=0; dependent 0x002101B3 accepted without stall.
REQ-023 Illegal opcode check:
- 0x0000007F -> illegal=1, reg_write=0, mem_write=0.
- 0x027302B3 -> md_en=1, md_op=000 with RV32M_EN; illegal=1 without it.

Source files
------------

// File: rtl/decode_ctrl_stage.sv
// Registered RV32 decode/control stage with load-use interlock and flush.
// Define RV32M_EN to decode multiply/divide (md_en/md_op); otherwise that encoding is illegal.
module decode_ctrl_stage #(
  parameter int XLEN         = 32,
  parameter int LOAD_USE_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [3:0]      alu_op,
  output logic            alu_src,
  output logic            alu_pc_src,
  output logic [2:0]      branch,
  output logic            jump,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic            mem_unsigned,
  output logic            illegal,
  output logic [1:0]      mem_size,
  output logic            md_en,
  output logic [2:0]      md_op
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [1:0] HZ_INIT   = 2'(LOAD_USE_LAT - 1);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            alu_pc_src;
    logic [2:0]      branch;
    logic            jump;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_unsigned;
    logic            illegal;
    logic [1:0]      mem_size;
    logic            md_en;
    logic [2:0]      md_op;
  } ctrl_t;

  // Idle bundle: no branch (011) and word size, matching the reset image.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c          = '0;
    c.branch   = 3'b011;
    c.mem_size = 2'b10;
    return c;
  endfunction

  function automatic logic reads_reg(input logic [4:0] a, input logic [4:0] b,
                                     input logic [4:0] r);
    return (r != 5'd0) && ((a == r) || (b == r));
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic [31:0] imm32;
  ctrl_t       dec, q;
  logic [4:0]  hz_rd;
  logic [1:0]  hz_cnt;
  logic        stall, accept;

  assign opcode = in_instr[6:0];
  assign rd_f   = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1_f  = in_instr[19:15];
  assign rs2_f  = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec   = ctrl_idle();
    imm32 = '0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000001) begin
`ifdef RV32M_EN
          dec.md_en     = 1'b1;
          dec.md_op     = funct3;
          dec.reg_write = 1'b1;
          dec.rs1       = rs1_f;
          dec.rs2       = rs2_f;
`else
          dec.illegal   = 1'b1;
`endif
        end else begin
          dec.reg_write = 1'b1;
          dec.alu_op    = {funct7[5], funct3};
          dec.rs1       = rs1_f;
          dec.rs2       = rs2_f;
        end
      end
      OP_IALU: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.rs1       = rs1_f;
        dec.alu_op    = (funct3 == 3'b001 || funct3 == 3'b101) ? {funct7[5], funct3}
                                                               : {1'b0, funct3};
        imm32         = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_LOAD: begin
        dec.reg_write    = 1'b1;
        dec.alu_src      = 1'b1;
        dec.mem_read     = 1'b1;
        dec.mem_to_reg   = 1'b1;
        dec.mem_unsigned = funct3[2];
        dec.mem_size     = funct3[1:0];
        dec.rs1          = rs1_f;
        imm32            = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.mem_size  = funct3[1:0];
        dec.rs1       = rs1_f;
        dec.rs2       = rs2_f;
        imm32         = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        dec.branch = funct3;
        dec.alu_op = 4'b1000;
        dec.rs1    = rs1_f;
        dec.rs2    = rs2_f;
        imm32      = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
      end
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        imm32         = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0};
      end
      OP_JALR: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.jump      = 1'b1;
        dec.rs1       = rs1_f;
        imm32         = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_LUI, OP_AUIPC: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_pc_src = (opcode == OP_AUIPC);
        imm32          = {in_instr[31:12], 12'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
    dec.rd  = dec.reg_write ? rd_f : 5'd0;
  end

  // A held load hazards on its own rd; once fired, hz_rd covers the remaining bubbles.
  assign stall = in_valid &&
                 ((out_valid && q.mem_read && reads_reg(dec.rs1, dec.rs2, q.rd)) ||
                  ((hz_cnt != 2'd0) && reads_reg(dec.rs1, dec.rs2, hz_rd)));

  assign in_ready = flush || ((!out_valid || out_ready) && !stall);
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      q         <= ctrl_idle();
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      q         <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hz_rd  <= 5'd0;
      hz_cnt <= 2'd0;
    end else if (flush) begin
      hz_cnt <= 2'd0;
    end else if (out_valid && out_ready && q.mem_read) begin
      hz_rd  <= q.rd;
      hz_cnt <= HZ_INIT;
    end else if (hz_cnt != 2'd0) begin
      hz_cnt <= hz_cnt - 2'd1;
    end
  end

  assign out_imm      = q.imm;
  assign out_rs1      = q.rs1;
  assign out_rs2      = q.rs2;
  assign out_rd       = q.rd;
  assign alu_op       = q.alu_op;
  assign alu_src      = q.alu_src;
  assign alu_pc_src   = q.alu_pc_src;
  assign branch       = q.branch;
  assign jump         = q.jump;
  assign mem_read     = q.mem_read;
  assign mem_write    = q.mem_write;
  assign reg_write    = q.reg_write;
  assign mem_to_reg   = q.mem_to_reg;
  assign mem_unsigned = q.mem_unsigned;
  assign illegal      = q.illegal;
  assign mem_size     = q.mem_size;
  assign md_en        = q.md_en;
  assign md_op        = q.md_op;

endmodule
